// File: rtl/tdp_ram_be.sv
// rtl/tdp_ram_be.sv - single-clock true dual-port RAM with byte enables, clear sequencer and collision flag
// Optional per-byte even parity storage/check: define TDP_RAM_PARITY_EN.
module tdp_ram_be #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int BYTE_WIDTH = 8,
   parameter int RD_LATENCY = 1,
   parameter int RDW_MODE   = 0,
   parameter int INIT_CLEAR = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               ena,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   wea,
   input  logic [ADDR_WIDTH-1:0]              addra,
   input  logic [DATA_WIDTH-1:0]              dina,
   output logic [DATA_WIDTH-1:0]              douta,
   output logic                               vlda,
   output logic                               perra,
   input  logic                               enb,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   web,
   input  logic [ADDR_WIDTH-1:0]              addrb,
   input  logic [DATA_WIDTH-1:0]              dinb,
   output logic [DATA_WIDTH-1:0]              doutb,
   output logic                               vldb,
   output logic                               perrb,
   output logic                               init_busy,
   output logic                               collision
);

   localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   typedef enum logic [0:0] {ST_CLEAR, ST_READY} state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   clr_addr;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    ready;
   logic                    wr_a, rd_a, wr_b, rd_b;
   logic                    same_addr;
   logic [DATA_WIDTH-1:0]   rdata_a, rdata_b;
   logic                    err_a, err_b;

   logic [DATA_WIDTH-1:0]   dout1_a, dout1_b;
   logic                    vld1_a, vld1_b, perr1_a, perr1_b;

   assign ready     = (state == ST_READY) && !rst;
   assign wr_a      = ready && ena && (|wea);
   assign rd_a      = ready && ena && !(|wea);
   assign wr_b      = ready && enb && (|web);
   assign rd_b      = ready && enb && !(|web);
   assign same_addr = (addra == addrb);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
         init_busy <= (INIT_CLEAR != 0);
         clr_addr  <= '0;
      end else if (state == ST_CLEAR) begin
         clr_addr <= clr_addr + ADDR_WIDTH'(1);
         if (clr_addr == LAST_ADDR) begin
            state     <= ST_READY;
            init_busy <= 1'b0;
         end
      end
   end

   // Port B lanes are assigned first so that port A wins overlapping lanes.
   always_ff @(posedge clk) begin
      if (state == ST_CLEAR) begin
         mem[clr_addr] <= '0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (wr_b && web[i])
               mem[addrb][i*BYTE_WIDTH +: BYTE_WIDTH] <= dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wr_a && wea[i])
               mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   always_comb begin
      rdata_a = mem[addra];
      rdata_b = mem[addrb];
      if (RDW_MODE == 1) begin
         for (int i = 0; i < NB; i++) begin
            if (wr_b && web[i] && same_addr)
               rdata_a[i*BYTE_WIDTH +: BYTE_WIDTH] = dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wr_a && wea[i] && same_addr)
               rdata_b[i*BYTE_WIDTH +: BYTE_WIDTH] = dina[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

`ifdef TDP_RAM_PARITY_EN
   logic [NB-1:0] par_mem [DEPTH];
   logic [NB-1:0] rpar_a, rpar_b;

   function automatic logic [NB-1:0] lane_par(input logic [DATA_WIDTH-1:0] d);
      logic [NB-1:0] p;
      for (int i = 0; i < NB; i++)
         p[i] = ^d[i*BYTE_WIDTH +: BYTE_WIDTH];
      return p;
   endfunction

   always_ff @(posedge clk) begin
      if (state == ST_CLEAR) begin
         par_mem[clr_addr] <= '0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (wr_b && web[i])
               par_mem[addrb][i] <= ^dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wr_a && wea[i])
               par_mem[addra][i] <= ^dina[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   always_comb begin
      rpar_a = par_mem[addra];
      rpar_b = par_mem[addrb];
      if (RDW_MODE == 1) begin
         for (int i = 0; i < NB; i++) begin
            if (wr_b && web[i] && same_addr)
               rpar_a[i] = ^dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wr_a && wea[i] && same_addr)
               rpar_b[i] = ^dina[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   assign err_a = |(lane_par(rdata_a) ^ rpar_a);
   assign err_b = |(lane_par(rdata_b) ^ rpar_b);
`else
   assign err_a = 1'b0;
   assign err_b = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         dout1_a   <= '0;
         dout1_b   <= '0;
         vld1_a    <= 1'b0;
         vld1_b    <= 1'b0;
         perr1_a   <= 1'b0;
         perr1_b   <= 1'b0;
         collision <= 1'b0;
      end else begin
         vld1_a    <= rd_a;
         vld1_b    <= rd_b;
         perr1_a   <= rd_a && err_a;
         perr1_b   <= rd_b && err_b;
         collision <= ready && ena && enb && same_addr && (wr_a || wr_b);
         if (rd_a)
            dout1_a <= rdata_a;
         if (rd_b)
            dout1_b <= rdata_b;
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic [DATA_WIDTH-1:0] dout2_a, dout2_b;
         logic                  vld2_a, vld2_b, perr2_a, perr2_b;

         always_ff @(posedge clk) begin
            if (rst) begin
               dout2_a <= '0;
               dout2_b <= '0;
               vld2_a  <= 1'b0;
               vld2_b  <= 1'b0;
               perr2_a <= 1'b0;
               perr2_b <= 1'b0;
            end else begin
               vld2_a  <= vld1_a;
               vld2_b  <= vld1_b;
               perr2_a <= perr1_a;
               perr2_b <= perr1_b;
               if (vld1_a)
                  dout2_a <= dout1_a;
               if (vld1_b)
                  dout2_b <= dout1_b;
            end
         end

         assign douta = dout2_a;
         assign doutb = dout2_b;
         assign vlda  = vld2_a;
         assign vldb  = vld2_b;
         assign perra = perr2_a;
         assign perrb = perr2_b;
      end else begin : g_lat1
         assign douta = dout1_a;
         assign doutb = dout1_b;
         assign vlda  = vld1_a;
         assign vldb  = vld1_b;
         assign perra = perr1_a;
         assign perrb = perr1_b;
      end
   endgenerate

endmodule

// File: tb/tb_tdp_ram_be.sv
// tb/tb_tdp_ram_be.sv - directed self-checking bench for tdp_ram_be (16-word instance)
// Parity checks are compiled in with TDP_RAM_PARITY_EN.
module tb_tdp_ram_be;

   localparam int DW     = 32;
   localparam int AW     = 4;
   localparam int NB     = 4;
   localparam int RD_LAT = 1;
   localparam int RDW    = 0;

   logic          clk = 1'b0;
   logic          rst;
   logic          ena, enb;
   logic [NB-1:0] wea, web;
   logic [AW-1:0] addra, addrb;
   logic [DW-1:0] dina, dinb;
   logic [DW-1:0] douta, doutb;
   logic          vlda, vldb, perra, perrb;
   logic          init_busy, collision;

   int total = 0;
   int bad   = 0;
   int n;
   logic seen;

   tdp_ram_be #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
      .RD_LATENCY(RD_LAT), .RDW_MODE(RDW), .INIT_CLEAR(1)
   ) dut (
      .clk(clk), .rst(rst),
      .ena(ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(douta), .vlda(vlda), .perra(perra),
      .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
      .doutb(doutb), .vldb(vldb), .perrb(perrb),
      .init_busy(init_busy), .collision(collision)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle();
      ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
   endtask

   task automatic wr_a(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] we);
      ena = 1'b1; wea = we; addra = a; dina = d;
      @(posedge clk); #1;
      idle();
   endtask

   task automatic read_a(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                         input logic exp_perr, input string tag);
      ena = 1'b1; wea = '0; addra = a;
      @(posedge clk); #1;
      idle();
      repeat (RD_LAT - 1) @(posedge clk);
      @(negedge clk);
      chk(tag, douta, exp);
      chk({tag, "_vld"}, vlda, 1);
      chk({tag, "_perr"}, perra, exp_perr);
   endtask

   task automatic read_b(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
      enb = 1'b1; web = '0; addrb = a;
      @(posedge clk); #1;
      idle();
      repeat (RD_LAT - 1) @(posedge clk);
      @(negedge clk);
      chk(tag, doutb, exp);
      chk({tag, "_vld"}, vldb, 1);
   endtask

   task automatic count_busy(output int cnt);
      cnt = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (!init_busy) break;
         cnt++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      addra = '0; addrb = '0; dina = '0; dinb = '0;
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_douta", douta, 0);
      chk("rst_doutb", doutb, 0);
      chk("rst_vlda", vlda, 0);
      chk("rst_vldb", vldb, 0);
      chk("rst_coll", collision, 0);
      chk("rst_busy", init_busy, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      count_busy(n);
      chk("clear_len", n, 16);

      read_a(5, 32'h0, 1'b0, "rd5_zero");
      @(negedge clk);
      chk("vlda_pulse", vlda, 0);

      wr_a(3, 32'hAABBCCDD, 4'b1111);
      @(negedge clk);
      chk("wr_no_vld", vlda, 0);
      chk("wr_dout_hold", douta, 0);
      wr_a(3, 32'h11223344, 4'b0101);
      read_b(3, 32'hAA22CC44, "be_merge");

      // write/write collision, full overlap: port A wins
      ena = 1'b1; wea = 4'b1111; addra = 7; dina = 32'h12345678;
      enb = 1'b1; web = 4'b1100; addrb = 7; dinb = 32'hFFFFFFFF;
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      chk("ww_coll", collision, 1);
      @(negedge clk);
      chk("ww_coll_pulse", collision, 0);
      read_a(7, 32'h12345678, 1'b0, "ww_a_wins");

      // write/write collision, disjoint lanes
      ena = 1'b1; wea = 4'b0001; addra = 8; dina = 32'h000000AA;
      enb = 1'b1; web = 4'b1000; addrb = 8; dinb = 32'hBB000000;
      @(posedge clk); #1;
      idle();
      read_b(8, 32'hBB0000AA, "ww_disjoint");

      // read/write collision on address 9
      ena = 1'b1; wea = 4'b1111; addra = 9; dina = 32'hCAFEF00D;
      enb = 1'b1; web = 4'b0000; addrb = 9;
      @(posedge clk); #1;
      idle();
      fork
         begin
            @(negedge clk);
            chk("rw_coll", collision, 1);
         end
         begin
            repeat (RD_LAT - 1) @(posedge clk);
            @(negedge clk);
            chk("rw_doutb", doutb, (RDW == 1) ? 32'hCAFEF00D : 32'h0);
            chk("rw_vldb", vldb, 1);
         end
      join
      read_a(9, 32'hCAFEF00D, 1'b0, "rw_landed");

      // read/read same address: no collision
      ena = 1'b1; addra = 3; enb = 1'b1; addrb = 3;
      @(posedge clk); #1;
      idle();
      fork
         begin
            @(negedge clk);
            chk("rr_no_coll", collision, 0);
         end
         begin
            repeat (RD_LAT - 1) @(posedge clk);
            @(negedge clk);
            chk("rr_douta", douta, 32'hAA22CC44);
            chk("rr_doutb", doutb, 32'hAA22CC44);
         end
      join

      // back-to-back reads
      fork
         begin
            ena = 1'b1; wea = '0; addra = 3;
            @(posedge clk); #1;
            addra = 7;
            @(posedge clk); #1;
            idle();
         end
         begin
            repeat (RD_LAT) @(posedge clk);
            @(negedge clk);
            chk("b2b_0", douta, 32'hAA22CC44);
            chk("b2b_0_vld", vlda, 1);
            @(negedge clk);
            chk("b2b_1", douta, 32'h12345678);
            chk("b2b_1_vld", vlda, 1);
         end
      join

      // reset in the 8th clear cycle restarts the clear; ports ignored meanwhile
      wr_a(2, 32'h00000055, 4'b1111);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("busy_mid", init_busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      ena = 1'b1; wea = 4'b1111; addra = 0; dina = 32'hDEADBEEF;
      enb = 1'b1; web = 4'b0000; addrb = 1;
      n = 0;
      seen = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (!init_busy) begin
            idle();
            break;
         end
         n++;
         seen = seen | vlda | vldb | collision;
      end
      chk("clear_len_restart", n, 16);
      chk("clear_quiet", seen, 0);
      read_a(0, 32'h0, 1'b0, "clr_no_write");
      read_a(2, 32'h0, 1'b0, "clr_zeroed");

`ifdef TDP_RAM_PARITY_EN
      wr_a(4, 32'h000000FF, 4'b1111);
      read_a(4, 32'h000000FF, 1'b0, "par_clean");
      dut.par_mem[4] = dut.par_mem[4] ^ 4'b0001;
      read_a(4, 32'h000000FF, 1'b1, "par_err");
      read_a(3, 32'h0, 1'b0, "par_other");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tdp_ram_be.md
Name: tdp_ram_be

Overview:
- Single-clock true dual-port RAM; successor to the dual-clock true dual-port RAM in the common building blocks.
- Adds per-byte write enables, selectable read latency (1 or 2), read-valid flags and a defined collision policy.
- Adds a post-reset clear sequencer that zeroes every word.
- Used as a shared buffer between two masters in the same clock domain.

Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 10, address width; DEPTH = 2**ADDR_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register).
- RDW_MODE, 0, cross-port read-during-write: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new data).
- INIT_CLEAR, 1, 1 = zero the memory after reset; 0 = skip the clear (contents undefined).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- ena  in  1  port A enable.
- wea  in  NB  port A byte write enables; any bit set = write, all zero = read.
- addra  in  ADDR_WIDTH  port A address.
- dina  in  DATA_WIDTH  port A write data.
- douta  out  DATA_WIDTH  port A read data.
- vlda  out  1  port A read data valid, one-cycle pulse.
- perra  out  1  port A parity error, qualified by vlda.
- enb / web / addrb / dinb / doutb / vldb / perrb  same as the port A signals, for port B.
- init_busy  out  1  clear sequence in progress.
- collision  out  1  one-cycle pulse: same-address access on both ports with at least one writing.

Behaviour:
- Reset (rst=1 at a clock edge):
  - douta, doutb = 0; vlda, vldb, perra, perrb, collision = 0; pipeline stages flushed.
  - FSM goes to CLEAR if INIT_CLEAR=1, otherwise to READY.
- FSM states:
  - CLEAR: one word per cycle, address 0 to DEPTH-1, written with all zeros (and correct parity when the parity feature is compiled in). init_busy=1. Both ports ignored: no writes, no vld, no collision.
  - CLEAR lasts exactly DEPTH cycles; the counter wraps at DEPTH-1, then the FSM goes to READY.
  - READY: init_busy=0; normal operation.
  - rst during CLEAR restarts the clear at address 0.
- Write: en=1 and we!=0. Only lanes with we[i]=1 are updated at the clock edge. No vld pulse; dout holds its value.
- Read: en=1 and we=0.
  - RD_LATENCY=1: dout valid and vld=1 on the cycle after the request.
  - RD_LATENCY=2: both arrive one cycle later.
  - Back-to-back reads give one result per cycle.
  - dout holds the last read value until the next read completes.
- Same-address collision (both ports enabled, equal addresses, at least one writing):
  - Write/write: per byte lane, port A wins where both wea[i] and web[i] are set; non-overlapping lanes from either port are written.
  - Read/write: reader gets the pre-write word if RDW_MODE=0, or the merged post-write word if RDW_MODE=1.
  - Read/read: both get the same data; collision=0.
  - collision is registered and pulses one cycle after the offending request cycle.
- Different addresses: both ports operate fully independently, with no stall.
- en=0 on a port: no access, vld stays 0, dout holds.

Optional Feature:
- Macro TDP_RAM_PARITY_EN.
- Defined: each byte lane stores one even-parity bit, generated on write and checked on read. perrX=1 together with vldX when any lane of the returned word mismatches. The clear sequence writes valid parity.
- Undefined: no parity storage; perra and perrb are tied to 0.

Test Plan:
- Reset, then count cycles with init_busy=1 (ADDR_WIDTH=4): expect exactly 16 cycles. Then read address 5 on port A: douta=0, vlda one cycle later (RD_LATENCY=1) or two cycles later (RD_LATENCY=2).
- Port A writes 0xAABBCCDD to address 3 with wea=4'b1111, then writes 0x11223344 with wea=4'b0101. A port B read of address 3 returns 0xAA22CC44.
- Same cycle, address 7: port A writes 0x12345678 with wea=4'b1111 and port B writes 0xFFFFFFFF with web=4'b1100. Address 7 ends as 0x12345678; collision pulses once.
- Address 9 holds 0x0. Port A writes 0xCAFEF00D while port B reads address 9 in the same cycle. doutb=0x0 with RDW_MODE=0, or 0xCAFEF00D with RDW_MODE=1.
- Assert rst at the 8th clear cycle: init_busy stays high for a full DEPTH cycles after release. Port writes issued during CLEAR do not land.
- With TDP_RAM_PARITY_EN: write 0x000000FF, then flip one stored parity bit by hierarchical force and read back. Expect perra=1 with vlda; a clean word gives perra=0.
